// File: rtl/musicbox_button_conditioner.sv
// Button conditioner for the MusicBox panel: per-channel 2-flop sync, polarity normalise, debounce, edge pulses.
// Optional long-press pulse on button_held, enabled by defining BUTTON_HOLD_DETECT_EN.
module musicbox_button_conditioner #(
  parameter int unsigned                    NUM_CHANNELS    = 10,
  parameter int unsigned                    DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_CHANNELS-1:0]        ACTIVE_LOW_MASK = {NUM_CHANNELS{1'b1}},
  parameter int unsigned                    HOLD_CYCLES     = 50000000
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] gpio_buttons_raw,
  output logic [NUM_CHANNELS-1:0] button_state,
  output logic [NUM_CHANNELS-1:0] button_pressed,
  output logic [NUM_CHANNELS-1:0] button_released,
  output logic [NUM_CHANNELS-1:0] button_held,
  output logic                    any_pressed
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_params
    $error("DEBOUNCE_CYCLES and HOLD_CYCLES must both be >= 2");
  end

  logic [NUM_CHANNELS-1:0] sync1_q, sync2_q;
  logic [NUM_CHANNELS-1:0] state_q, state_d;
  logic [NUM_CHANNELS-1:0] prev_q;
  logic [NUM_CHANNELS-1:0] pressed_q, released_q;
  logic                    any_pressed_q;
  logic [NUM_CHANNELS-1:0] norm;
  logic [DB_W-1:0]         db_cnt_q [NUM_CHANNELS];
  logic [DB_W-1:0]         db_cnt_d [NUM_CHANNELS];

  assign norm = sync2_q ^ ACTIVE_LOW_MASK;

  // Debounce: any sample matching the current state restarts the stability count
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      db_cnt_d[i] = '0;
      if (norm[i] != state_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          state_d[i] = ~state_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Sync flops reset to the idle pin level so reset release never looks like a press
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      sync1_q       <= ACTIVE_LOW_MASK;
      sync2_q       <= ACTIVE_LOW_MASK;
      state_q       <= '0;
      prev_q        <= '0;
      pressed_q     <= '0;
      released_q    <= '0;
      any_pressed_q <= 1'b0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= gpio_buttons_raw;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      prev_q        <= state_q;
      pressed_q     <= state_q & ~prev_q;
      released_q    <= ~state_q & prev_q;
      any_pressed_q <= |state_q;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign button_state    = state_q;
  assign button_pressed  = pressed_q;
  assign button_released = released_q;
  assign any_pressed     = any_pressed_q;

`ifdef BUTTON_HOLD_DETECT_EN
  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0]       hold_cnt_q [NUM_CHANNELS];
  logic [HOLD_W-1:0]       hold_cnt_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] hold_done_q, hold_done_d;
  logic [NUM_CHANNELS-1:0] held_q, held_d;

  // Counter parks at the threshold; done flag blocks repeats until release
  always_comb begin
    held_d      = '0;
    hold_done_d = hold_done_q;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      hold_cnt_d[i] = hold_cnt_q[i];
      if (!state_q[i]) begin
        hold_cnt_d[i]  = '0;
        hold_done_d[i] = 1'b0;
      end else if (hold_cnt_q[i] != HOLD_LAST) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
      end else if (!hold_done_q[i]) begin
        held_d[i]      = 1'b1;
        hold_done_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      hold_done_q <= '0;
      held_q      <= '0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        hold_cnt_q[i] <= '0;
      end
    end else begin
      hold_done_q <= hold_done_d;
      held_q      <= held_d;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign button_held = held_q;
`else
  assign button_held = '0;
`endif

endmodule

// File: tb/tb_musicbox_button_conditioner.sv
// Scoreboard bench for musicbox_button_conditioner: expected pulse events are queued with their
// due cycle when pins are driven, and matched against every pulse the DUT emits.
module tb_musicbox_button_conditioner;

  localparam logic [3:0] IDLE = 4'b0011;
`ifdef BUTTON_HOLD_DETECT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw;
  logic [3:0] button_state, button_pressed, button_released, button_held;
  logic       any_pressed;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int c, r;

  logic [43:0] exp_q[$];
  logic [43:0] obs_evt, exp_evt;

  musicbox_button_conditioner #(
    .NUM_CHANNELS   (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_MASK(4'b0011),
    .HOLD_CYCLES    (10)
  ) dut (
    .clock_50Mhz     (clk),
    .reset           (reset),
    .gpio_buttons_raw(raw),
    .button_state    (button_state),
    .button_pressed  (button_pressed),
    .button_released (button_released),
    .button_held     (button_held),
    .any_pressed     (any_pressed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event word: {cycle, pressed, released, held}
  function automatic logic [43:0] mk(input int t, input logic [3:0] pr, input logic [3:0] rl,
                                     input logic [3:0] hd);
    return {32'(t), pr, rl, hd};
  endfunction

  function automatic logic [16:0] outs();
    return {button_state, button_pressed, button_released, button_held, any_pressed};
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Every pulse the DUT emits must match the next queued expectation
  always @(negedge clk) begin
    if ((button_pressed | button_released | button_held) != 4'b0000) begin
      obs_evt = mk(cyc, button_pressed, button_released, button_held);
      if (exp_q.size() == 0) begin
        check("unexpected_evt", 64'(obs_evt), 64'd0);
      end else begin
        exp_evt = exp_q.pop_front();
        check("evt", 64'(obs_evt), 64'(exp_evt));
      end
    end
  end

  initial begin
    raw   = IDLE;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_outs", 64'(outs()), 64'd0);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("idle_outs", 64'(outs()), 64'd0);
    end

    // ch0 (active-low) press and release
    c = cyc; raw[0] = 1'b0;
    exp_q.push_back(mk(c + 7, 4'b0001, 4'b0000, 4'b0000));
    wait_cyc(c + 5); check("s1_state_c5", 64'(button_state), 64'd0);
    wait_cyc(c + 6); check("s1_state_c6", 64'(button_state), 64'b0001);
    check("s1_any_c6", 64'(any_pressed), 64'd0);
    wait_cyc(c + 7); check("s1_any_c7", 64'(any_pressed), 64'd1);
    c = cyc; raw[0] = 1'b1;
    exp_q.push_back(mk(c + 7, 4'b0000, 4'b0001, 4'b0000));
    wait_cyc(c + 6); check("s1_rel_state", 64'(button_state), 64'd0);
    wait_cyc(c + 10);

    // ch0 glitch of DEBOUNCE-1 cycles is rejected
    c = cyc; raw[0] = 1'b0;
    wait_cyc(c + 3); raw[0] = 1'b1;
    wait_cyc(c + 10); check("glitch3_state", 64'(button_state), 64'd0);

    // ch0 pulse of exactly DEBOUNCE cycles is accepted, then released
    c = cyc; raw[0] = 1'b0;
    exp_q.push_back(mk(c + 7, 4'b0001, 4'b0000, 4'b0000));
    exp_q.push_back(mk(c + 11, 4'b0000, 4'b0001, 4'b0000));
    wait_cyc(c + 4); raw[0] = 1'b1;
    wait_cyc(c + 6);  check("pulse4_state_up", 64'(button_state), 64'b0001);
    wait_cyc(c + 10); check("pulse4_state_dn", 64'(button_state), 64'd0);
    wait_cyc(c + 15);

    // ch2 (active-high) bounces every 2 cycles, then settles pressed
    for (int k = 0; k < 10; k++) begin
      raw[2] = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    check("bounce_state", 64'(button_state), 64'd0);
    c = cyc; raw[2] = 1'b1;
    exp_q.push_back(mk(c + 7, 4'b0100, 4'b0000, 4'b0000));
    wait_cyc(c + 6); check("bounce_settled", 64'(button_state), 64'b0100);
    wait_cyc(c + 7);
    c = cyc; raw[2] = 1'b0;
    exp_q.push_back(mk(c + 7, 4'b0000, 4'b0100, 4'b0000));
    wait_cyc(c + 10);

    // ch1 and ch3 pressed together for 20 cycles
    c = cyc; raw[1] = 1'b0; raw[3] = 1'b1;
    exp_q.push_back(mk(c + 7, 4'b1010, 4'b0000, 4'b0000));
    if (HOLD_EN) exp_q.push_back(mk(c + 16, 4'b0000, 4'b0000, 4'b1010));
    wait_cyc(c + 8); check("pair_state", 64'(button_state), 64'b1010);
    check("pair_any", 64'(any_pressed), 64'd1);
    wait_cyc(c + 20);
    c = cyc; raw[1] = 1'b1; raw[3] = 1'b0;
    exp_q.push_back(mk(c + 7, 4'b0000, 4'b1010, 4'b0000));
    wait_cyc(c + 8); check("pair_any_off", 64'(any_pressed), 64'd0);
    wait_cyc(c + 12);

    // ch3 held 30 cycles: single long-press pulse when enabled
    c = cyc; raw[3] = 1'b1;
    exp_q.push_back(mk(c + 7, 4'b1000, 4'b0000, 4'b0000));
    if (HOLD_EN) exp_q.push_back(mk(c + 16, 4'b0000, 4'b0000, 4'b1000));
    wait_cyc(c + 15); check("hold_pre", 64'(button_held), 64'd0);
    wait_cyc(c + 16); check("hold_at", 64'(button_held), HOLD_EN ? 64'b1000 : 64'd0);
    wait_cyc(c + 17); check("hold_after", 64'(button_held), 64'd0);
    wait_cyc(c + 30);
    c = cyc; raw[3] = 1'b0;
    exp_q.push_back(mk(c + 7, 4'b0000, 4'b1000, 4'b0000));
    wait_cyc(c + 10);

    // reset while ch0 pressed: clear silently, then re-detect after release
    c = cyc; raw[0] = 1'b0;
    exp_q.push_back(mk(c + 7, 4'b0001, 4'b0000, 4'b0000));
    wait_cyc(c + 8); check("prerst_state", 64'(button_state), 64'b0001);
    reset = 1'b1;
    wait_cyc(c + 9);  check("midrst_outs", 64'(outs()), 64'd0);
    wait_cyc(c + 11); check("midrst_outs2", 64'(outs()), 64'd0);
    reset = 1'b0; r = cyc;
    exp_q.push_back(mk(r + 7, 4'b0001, 4'b0000, 4'b0000));
    wait_cyc(r + 5); check("postrst_c5", 64'(button_state), 64'd0);
    wait_cyc(r + 6); check("postrst_c6", 64'(button_state), 64'b0001);
    wait_cyc(r + 7);
    c = cyc; raw[0] = 1'b1;
    exp_q.push_back(mk(c + 7, 4'b0000, 4'b0001, 4'b0000));
    wait_cyc(c + 20);

    check("evt_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_outs", 64'(outs()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
